// File: rtl/io_bus_peripheral_pkg.sv
// Shared definitions for the io_bus_peripheral register map and CTRL register layout.
// Imported by the top and by the transmit FIFO.
package io_bus_peripheral_pkg;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_TCNT   = 2'd1,
        REG_TCMP   = 2'd2,
        REG_CTRL   = 2'd3
    } reg_idx_e;

    localparam int CTRL_IRQ = 0;
    localparam int CTRL_EN  = 1;
    localparam int CTRL_OVF = 2;

    // Fifo occupancy as presented on the bus is 5 bits wide, enough for a depth of 16.
    localparam int COUNT_W = 5;

    function automatic logic [31:0] pack_ctrl(input logic ovf, input logic en, input logic irq);
        logic [31:0] v;
        v           = '0;
        v[CTRL_OVF] = ovf;
        v[CTRL_EN]  = en;
        v[CTRL_IRQ] = irq;
        return v;
    endfunction

endpackage

// File: rtl/io_bus_peripheral_tx_fifo.sv
// Byte transmit FIFO: circular buffer with occupancy count, push-through-pop when full,
// and an overflow strobe when a push is dropped.
module io_bus_peripheral_tx_fifo
    import io_bus_peripheral_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_empty,
    output logic               o_full,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [COUNT_W-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == COUNT_W'(DEPTH));
    assign o_count    = r_count;
    assign o_data     = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_overflow = i_push && o_full && !w_pop_ok;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally at AW bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_peripheral.sv
// Memory-mapped peripheral: byte TX FIFO with valid/ready drain plus a prescaled
// 32-bit compare timer with sticky irq; reads are combinational for same-cycle sampling.
module io_bus_peripheral
    import io_bus_peripheral_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 1,
    parameter int ADDR_LSB   = 0
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic [31:0] ADDR,
    input  logic        CS,
    input  logic        WR_RD,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic [7:0]  r_presc;
    logic        r_en;
    logic        r_irq;
    logic        r_ovf;

    reg_idx_e           w_idx;
    logic               w_wr;
    logic               w_wr_txdata;
    logic               w_wr_tcnt;
    logic               w_wr_tcmp;
    logic               w_wr_ctrl;
    logic               w_en_drop;
    logic               w_presc_last;
    logic               w_tick;
    logic               w_match;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_fifo_ovf;
    logic [COUNT_W-1:0] w_fifo_count;
    logic               w_unused_bits;

    assign w_idx       = reg_idx_e'(ADDR[ADDR_LSB+1:ADDR_LSB]);
    assign w_wr        = CS && WR_RD;
    assign w_wr_txdata = w_wr && (w_idx == REG_TXDATA);
    assign w_wr_tcnt   = w_wr && (w_idx == REG_TCNT);
    assign w_wr_tcmp   = w_wr && (w_idx == REG_TCMP);
    assign w_wr_ctrl   = w_wr && (w_idx == REG_CTRL);

    // Only the index field and the low data bits matter; the rest is folded here.
    assign w_unused_bits = ^{ADDR, Data_BUS_WRITE};

    io_bus_peripheral_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .i_clk      (CLK),
        .i_rst_n    (Rst),
        .i_push     (w_wr_txdata),
        .i_data     (Data_BUS_WRITE[7:0]),
        .i_pop      (tx_ready),
        .o_data     (tx_data),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full),
        .o_count    (w_fifo_count),
        .o_overflow (w_fifo_ovf)
    );

    assign tx_valid = !w_fifo_empty;
    assign irq      = r_irq;

    // A CTRL write clearing en, or a TCNT load, takes the whole tick away for this cycle.
    assign w_en_drop    = w_wr_ctrl && !Data_BUS_WRITE[CTRL_EN];
    assign w_presc_last = (r_presc == 8'(PRESCALE - 1));
    assign w_tick       = r_en && w_presc_last && !w_en_drop && !w_wr_tcnt;
    assign w_match      = (r_cnt == r_cmp);

    always_ff @(posedge CLK) begin
        if (!Rst) begin
            r_cnt   <= '0;
            r_presc <= '0;
        end else if (w_wr_tcnt) begin
            r_cnt   <= Data_BUS_WRITE;
            r_presc <= '0;
        end else if (r_en && !w_en_drop) begin
            r_presc <= w_presc_last ? 8'd0 : r_presc + 8'd1;
            if (w_tick) begin
                r_cnt <= w_match ? 32'd0 : r_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Rst) begin
            r_cmp <= '0;
            r_en  <= 1'b0;
        end else begin
            if (w_wr_tcmp) begin
                r_cmp <= Data_BUS_WRITE;
            end
            if (w_wr_ctrl) begin
                r_en <= Data_BUS_WRITE[CTRL_EN];
            end
        end
    end

    // Set events win over software clears landing on the same edge.
    always_ff @(posedge CLK) begin
        if (!Rst) begin
            r_irq <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_tick && w_match) begin
                r_irq <= 1'b1;
            end else if (w_wr_ctrl && Data_BUS_WRITE[CTRL_IRQ]) begin
                r_irq <= 1'b0;
            end
            if (w_fifo_ovf) begin
                r_ovf <= 1'b1;
            end else if (w_wr_ctrl && Data_BUS_WRITE[CTRL_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        Data_BUS_READ = '0;
        if (CS && !WR_RD) begin
            case (w_idx)
                REG_TXDATA: Data_BUS_READ = {27'b0, w_fifo_count};
                REG_TCNT:   Data_BUS_READ = r_cnt;
                REG_TCMP:   Data_BUS_READ = r_cmp;
                REG_CTRL:   Data_BUS_READ = pack_ctrl(r_ovf, r_en, r_irq);
                default:    Data_BUS_READ = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_peripheral.sv
// Self-checking bench for io_bus_peripheral: directed scenarios plus random bus traffic,
// with read data and drained bytes compared against a behavioural model via queues.
module tb_io_bus_peripheral;

  localparam int DEPTH = 4;
  localparam int PRESC = 1;
  localparam int LSB   = 2;

  logic        CLK = 1'b0;
  logic        Rst;
  logic [31:0] ADDR;
  logic        CS;
  logic        WR_RD;
  logic [31:0] Data_BUS_WRITE;
  logic [31:0] Data_BUS_READ;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];

  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  int          m_presc;
  logic        m_en;
  logic        m_irq;
  logic        m_ovf;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  io_bus_peripheral #(
    .FIFO_DEPTH (DEPTH),
    .PRESCALE   (PRESC),
    .ADDR_LSB   (LSB)
  ) dut (
    .CLK            (CLK),
    .Rst            (Rst),
    .ADDR           (ADDR),
    .CS             (CS),
    .WR_RD          (WR_RD),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .Data_BUS_READ  (Data_BUS_READ),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .irq            (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    tx_q.delete();
    m_cnt   = '0;
    m_cmp   = '0;
    m_presc = 0;
    m_en    = 1'b0;
    m_irq   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'(tx_q.size());
      2'd1:    return m_cnt;
      2'd2:    return m_cmp;
      default: return {29'b0, m_ovf, m_en, m_irq};
    endcase
  endfunction

  // Advance the model across the coming rising edge using the inputs now on the bus.
  task automatic m_step();
    logic        wr;
    logic [1:0]  idx;
    logic [31:0] wd;
    bit          ovf_set;
    bit          tcnt_wr;
    bit          ctrl_wr;
    bit          en_drop;
    bit          tick;
    bit          hit;
    if (!Rst) begin
      m_reset();
      return;
    end
    wr      = CS && WR_RD;
    idx     = ADDR[LSB+1:LSB];
    wd      = Data_BUS_WRITE;
    ovf_set = 0;
    tick    = 0;
    hit     = 0;
    if (tx_q.size() > 0 && tx_ready) void'(tx_q.pop_front());
    if (wr && idx == 2'd0) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(wd[7:0]);
      else ovf_set = 1;
    end
    tcnt_wr = wr && idx == 2'd1;
    ctrl_wr = wr && idx == 2'd3;
    en_drop = ctrl_wr && !wd[1];
    if (tcnt_wr) begin
      m_cnt   = wd;
      m_presc = 0;
    end else if (m_en && !en_drop) begin
      m_presc = (m_presc + 1) % PRESC;
      tick    = (m_presc == 0);
    end
    if (tick) begin
      hit   = (m_cnt == m_cmp);
      m_cnt = hit ? 32'd0 : m_cnt + 32'd1;
    end
    if (tick && hit) m_irq = 1'b1;
    else if (ctrl_wr && wd[0]) m_irq = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
    else if (ctrl_wr && wd[2]) m_ovf = 1'b0;
    if (ctrl_wr) m_en = wd[1];
    if (wr && idx == 2'd2) m_cmp = wd;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (CS && !WR_RD) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read at %0t", Data_BUS_READ, $time);
      end else begin
        chk("rd_data", Data_BUS_READ, exp_q.pop_front());
      end
    end else begin
      chk("rd_idle_zero", Data_BUS_READ, 32'd0);
    end
    chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
    chk("irq", 32'(irq), 32'(m_irq));
    if (tx_valid && tx_ready && tx_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
    m_step();
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input bit cs, input bit wr, input logic [1:0] idx,
                     input logic [31:0] wd, input bit rdy);
    @(posedge CLK);
    #1;
    CS                  = cs;
    WR_RD               = wr;
    ADDR                = $urandom;
    ADDR[LSB+1:LSB]     = idx;
    Data_BUS_WRITE      = wd;
    tx_ready            = rdy;
  endtask

  task automatic rd(input logic [1:0] idx, input bit rdy);
    bus(1'b1, 1'b0, idx, $urandom, rdy);
    exp_q.push_back(m_read(idx));
  endtask

  task automatic rd_exp(input logic [1:0] idx, input logic [31:0] exp, input bit rdy);
    bus(1'b1, 1'b0, idx, $urandom, rdy);
    exp_q.push_back(exp);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] wd, input bit rdy);
    bus(1'b1, 1'b1, idx, wd, rdy);
  endtask

  task automatic idle(input bit rdy);
    bus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, rdy);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] drain_exp [4];

  initial begin
    Rst = 1'b0; CS = 1'b0; WR_RD = 1'b0; ADDR = '0; Data_BUS_WRITE = '0; tx_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1 Rst = 1'b1;

    // reset state
    rd_exp(2'd0, 32'd0, 1'b0);
    rd_exp(2'd3, 32'd0, 1'b0);
    rd_exp(2'd1, 32'd0, 1'b0);
    rd_exp(2'd2, 32'd0, 1'b0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);

    // three pushes held, then drained in order
    wr(2'd0, 32'h41, 1'b0);
    wr(2'd0, 32'h42, 1'b0);
    wr(2'd0, 32'h43, 1'b0);
    rd_exp(2'd0, 32'd3, 1'b0);
    chk("held_valid", 32'(tx_valid), 32'd1);
    chk("held_head", 32'(tx_data), 32'h41);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("drain_seq", 32'(tx_data), 32'h41 + 32'(i));
    end
    idle(1'b0);
    chk("drained_valid", 32'(tx_valid), 32'd0);

    // overflow, then push-through-pop at full
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h50 + 32'(i), 1'b0);
    rd_exp(2'd0, 32'd4, 1'b0);
    rd_exp(2'd3, 32'h4, 1'b0);
    wr(2'd0, 32'h99, 1'b1);
    rd_exp(2'd0, 32'd4, 1'b0);
    drain_exp[0] = 8'h51; drain_exp[1] = 8'h52; drain_exp[2] = 8'h53; drain_exp[3] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("full_drain_seq", 32'(tx_data), 32'(drain_exp[i]));
    end
    idle(1'b0);
    wr(2'd3, 32'h4, 1'b0);
    rd_exp(2'd3, 32'd0, 1'b0);

    // push and pop together while empty
    wr(2'd0, 32'h77, 1'b1);
    rd_exp(2'd0, 32'd1, 1'b0);
    chk("empty_pushpop_head", 32'(tx_data), 32'h77);
    idle(1'b1);
    idle(1'b0);

    // write with CS low has no effect
    bus(1'b0, 1'b1, 2'd2, 32'hDEAD, 1'b0);
    rd_exp(2'd2, 32'd0, 1'b0);

    // timer count/match sequence
    wr(2'd1, 32'd0, 1'b0);
    wr(2'd2, 32'd3, 1'b0);
    wr(2'd3, 32'h2, 1'b0);
    rd_exp(2'd1, 32'd0, 1'b0);
    rd_exp(2'd1, 32'd1, 1'b0);
    rd_exp(2'd1, 32'd2, 1'b0);
    rd_exp(2'd1, 32'd3, 1'b0);
    chk("irq_before_match", 32'(irq), 32'd0);
    rd_exp(2'd1, 32'd0, 1'b0);
    chk("irq_after_match", 32'(irq), 32'd1);
    rd_exp(2'd3, 32'h3, 1'b0);
    wr(2'd3, 32'h3, 1'b0);
    rd_exp(2'd3, 32'h2, 1'b0);
    // match landing on the same edge as an irq clear
    repeat (3) idle(1'b0);
    wr(2'd3, 32'h3, 1'b0);
    rd_exp(2'd3, 32'h3, 1'b0);
    // TCNT load against a tick, then en 1->0 freezing the counter
    wr(2'd1, 32'h10, 1'b0);
    rd_exp(2'd1, 32'h10, 1'b0);
    rd_exp(2'd1, 32'h11, 1'b0);
    wr(2'd3, 32'h1, 1'b0);
    rd_exp(2'd1, 32'h12, 1'b0);
    rd_exp(2'd3, 32'd0, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int op;
      bit rdy;
      op  = int'($urandom_range(0, 9));
      rdy = 1'($urandom_range(0, 2) == 0);
      case (op)
        0, 1, 2, 3: rd(2'($urandom_range(0, 3)), rdy);
        4, 5:       wr(2'd0, $urandom, rdy);
        6:          wr(2'd1, 32'($urandom_range(0, 8)), rdy);
        7:          wr(2'd2, 32'($urandom_range(0, 6)), rdy);
        8:          wr(2'd3, 32'($urandom_range(0, 7)) | 32'h2, rdy);
        default:    idle(rdy);
      endcase
    end

    // reset asserted mid-traffic
    wr(2'd3, 32'h2, 1'b0);
    for (int i = 0; i < 3; i++) wr(2'd0, $urandom, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      #1;
      Rst = 1'b0; CS = 1'b1; WR_RD = 1'b1;
      ADDR = $urandom; Data_BUS_WRITE = $urandom; tx_ready = 1'b1;
    end
    @(posedge CLK);
    #1;
    Rst = 1'b1; CS = 1'b0; WR_RD = 1'b0; tx_ready = 1'b0;
    chk("post_rst_valid", 32'(tx_valid), 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    chk("post_rst_tx_data", 32'(tx_data), 32'd0);
    rd_exp(2'd0, 32'd0, 1'b0);
    rd_exp(2'd3, 32'd0, 1'b0);
    rd_exp(2'd1, 32'd0, 1'b0);

    repeat (3) idle(1'b0);
    @(posedge CLK);
    #1;
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_peripheral.md
Name: io_bus_peripheral

Overview:
- Memory-mapped peripheral on the CPU's external data bus. It consumes ADDR, CS, WR_RD and Data_BUS_WRITE from the memory stage and returns Data_BUS_READ in the same cycle.
- Contains a byte-wide transmit FIFO with a valid/ready drain port, plus a 32-bit compare timer with a sticky interrupt flag.
- Sits directly downstream of the CPU's memory stage. It is the external-side consumer of every CS=1 access.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16)
PRESCALE, 1, CLK cycles per timer tick (1..256)
ADDR_LSB, 0, ADDR bit at which the 2-bit register index starts

Ports:
CLK  input  1  system clock (CPU CLK_SYS domain)
Rst  input  1  synchronous reset, active-low
ADDR  input  32  bus address; index = ADDR[ADDR_LSB+1:ADDR_LSB]
CS  input  1  1 = access targets this block
WR_RD  input  1  1 = write, 0 = read
Data_BUS_WRITE  input  32  write data
Data_BUS_READ  output  32  read data, combinational from ADDR/state
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head this cycle
irq  output  1  timer match flag (sticky)

Behaviour:
- All state updates on rising CLK. Rst=0 at an edge clears everything, overriding any concurrent access or handshake. Reset values: FIFO empty, tx_valid=0, tx_data=0, cnt=0, cmp=0, prescaler=0, en=0, irq=0, ovf=0.
- A write commits at the edge where CS=1 and WR_RD=1. Reads have no side effects.
- Data_BUS_READ equals the selected register when CS=1 and WR_RD=0; otherwise it is 0. Zero latency, because the CPU samples it in the same cycle.
- Register map:
  - idx0 TXDATA: write pushes Data_BUS_WRITE[7:0]. Read returns {24'b0, 3'b0, count[4:0]}.
  - idx1 TCNT: read returns cnt; write loads cnt and clears the prescaler.
  - idx2 TCMP: read/write cmp.
  - idx3 CTRL: read returns {29'b0, ovf, en, irq}. Write: bit1 loads en; bit0=1 clears irq; bit2=1 clears ovf.
- FIFO:
  - Pop occurs when tx_valid && tx_ready. tx_data shows the head combinationally from storage.
  - A push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (full, push and pop together keeps count=DEPTH).
  - A push when full with no pop drops the byte and sets ovf (sticky).
  - Push and pop together when empty: the byte is accepted, count becomes 1, no pop occurs (tx_valid was 0).
  - Read/write pointers wrap modulo FIFO_DEPTH. count ranges 0..DEPTH.
- Timer:
  - When en=1, the prescaler counts 0..PRESCALE-1. At PRESCALE-1 a tick occurs and the prescaler returns to 0.
  - On a tick: if cnt==cmp, then cnt<=0 and irq<=1; else cnt<=cnt+1 (32-bit wrap).
  - en=0 freezes both cnt and the prescaler.
- Simultaneous events:
  - A TCNT write beats a same-cycle tick.
  - An irq set from a match beats a same-cycle CTRL bit0 clear.
  - An ovf set beats a same-cycle bit2 clear.
  - A CTRL write with en 1->0 suppresses a tick in that cycle.
- cmp=0 with en=1: irq sets on every tick, and cnt stays 0.

Decomposition:
- Shared package holds the register index constants (REG_TXDATA=0, REG_TCNT=1, REG_TCMP=2, REG_CTRL=3) and the CTRL bit positions (IRQ=0, EN=1, OVF=2).
- One sub-module: tx_fifo (parameterised depth/width, push/pop/full/empty/count).
- Timer, decode and read mux stay in the top.

Test Plan:
- Reset: drive Rst=0 for 2 cycles mid-traffic -> all outputs 0, CTRL reads 0, TXDATA reads count 0.
- Push 0x41,0x42,0x43 with tx_ready=0 -> TXDATA reads 3, tx_valid=1, tx_data=0x41. Then tx_ready=1 -> 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0.
- Push 5 bytes with tx_ready=0, DEPTH=4 -> count=4, ovf=1 (CTRL reads 0x4), 5th byte absent. Push while popping at full -> count stays 4, byte appears last.
- PRESCALE=1, TCMP=3, CTRL=0x2 -> cnt 0,1,2,3,0, irq rises on the edge cnt 3->0. Write CTRL=0x3 -> irq clears, en stays 1.
- TCNT write 0x10 in the same cycle as a tick -> cnt=0x10 next cycle. Match coinciding with a CTRL bit0 clear -> irq remains 1.
- CS=0 or WR_RD=1 -> Data_BUS_READ=0. Write with CS=0 -> no state change.
